// File: rtl/video_linebuf_ctrl.sv
// Double-buffered video line buffer controller.
// The display reads one pixel bank while the renderer fills the other.
// The banks swap at the end of each line if the new line is ready.
// If the line is not ready, an underrun is flagged and the in-progress render is aborted.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | no render outstanding (enable low or target line inactive)
// ST_RENDER| render requested, renderer may write the render bank
// ST_DONE  | renderer finished, bank swap pending at next start_of_line
module video_linebuf_ctrl #(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int V_TOTAL  = 525
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_of_screen,
    input  logic        start_of_line,
    input  logic        enable,
    input  logic [9:0]  disp_idx,
    output logic [11:0] disp_rgb,
    output logic        render_start,
    output logic        render_abort,
    output logic [8:0]  render_line,
    input  logic        render_done,
    input  logic        wr_en,
    input  logic [9:0]  wr_idx,
    input  logic [11:0] wr_data,
    output logic        busy,
    output logic        underrun,
    output logic [7:0]  underrun_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RENDER = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    localparam logic [9:0]  Y_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0]  V_ACT    = 10'(V_ACTIVE);
    localparam logic [10:0] H_LIMIT  = 11'(H_ACTIVE);

    state_t      state_q, state_d;
    logic [9:0]  y_q, y_d;
    logic        disp_bank_q, disp_bank_d;
    logic [8:0]  render_line_q, render_line_d;
    logic [7:0]  underrun_cnt_q, underrun_cnt_d;
    logic        render_start_q, render_start_d;
    logic        render_abort_q, render_abort_d;
    logic        underrun_q, underrun_d;

    logic [9:0]  rd_idx_q;
    logic        rd_bank_q;
    logic [11:0] disp_rgb_q;

    logic [11:0] bank0_q [H_ACTIVE];
    logic [11:0] bank1_q [H_ACTIVE];

    logic [9:0]  y_next_w;
    logic [9:0]  target_w;
    logic        line_ready_w;
    logic        wr_ok_w;

    assign y_next_w     = start_of_screen ? 10'd0 : (y_q + 10'd1);
    assign target_w     = (y_next_w == Y_LAST) ? 10'd0 : (y_next_w + 10'd1);
    assign line_ready_w = (state_q == ST_DONE) || ((state_q == ST_RENDER) && render_done);
    assign wr_ok_w      = wr_en && (state_q == ST_RENDER) && ({1'b0, wr_idx} < H_LIMIT);

    // Next-state and pulse generation; all decisions are taken on the line boundary.
    always_comb begin
        state_d        = state_q;
        y_d            = y_q;
        disp_bank_d    = disp_bank_q;
        render_line_d  = render_line_q;
        underrun_cnt_d = underrun_cnt_q;
        render_start_d = 1'b0;
        render_abort_d = 1'b0;
        underrun_d     = 1'b0;

        if (start_of_line) begin
            y_d = y_next_w;
            if (line_ready_w) begin
                disp_bank_d = ~disp_bank_q;
            end else if (state_q == ST_RENDER) begin
                // A disabled controller cancels quietly; otherwise this is a missed deadline.
                render_abort_d = 1'b1;
                if (enable) begin
                    underrun_d = 1'b1;
                    if (underrun_cnt_q != 8'hFF) begin
                        underrun_cnt_d = underrun_cnt_q + 8'd1;
                    end
                end
            end
            if (enable && (target_w < V_ACT)) begin
                render_start_d = 1'b1;
                render_line_d  = target_w[8:0];
                state_d        = ST_RENDER;
            end else begin
                state_d = ST_IDLE;
            end
        end else if ((state_q == ST_RENDER) && render_done) begin
            state_d = ST_DONE;
        end
    end

    // Control state register with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            y_q            <= 10'd0;
            disp_bank_q    <= 1'b0;
            render_line_q  <= 9'd0;
            underrun_cnt_q <= 8'd0;
            render_start_q <= 1'b0;
            render_abort_q <= 1'b0;
            underrun_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            y_q            <= y_d;
            disp_bank_q    <= disp_bank_d;
            render_line_q  <= render_line_d;
            underrun_cnt_q <= underrun_cnt_d;
            render_start_q <= render_start_d;
            render_abort_q <= render_abort_d;
            underrun_q     <= underrun_d;
        end
    end

    // Renderer writes land in the bank the display is not using; contents are never reset.
    always_ff @(posedge clk) begin
        if (wr_ok_w && disp_bank_q) begin
            bank0_q[wr_idx] <= wr_data;
        end
        if (wr_ok_w && !disp_bank_q) begin
            bank1_q[wr_idx] <= wr_data;
        end
    end

    // Display read stage 1: capture index and bank selection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_idx_q  <= 10'd0;
            rd_bank_q <= 1'b0;
        end else begin
            rd_idx_q  <= disp_idx;
            rd_bank_q <= disp_bank_q;
        end
    end

    // Display read stage 2: register pixel data; out-of-range indices read as black.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            disp_rgb_q <= 12'd0;
        end else if ({1'b0, rd_idx_q} < H_LIMIT) begin
            disp_rgb_q <= rd_bank_q ? bank1_q[rd_idx_q] : bank0_q[rd_idx_q];
        end else begin
            disp_rgb_q <= 12'd0;
        end
    end

    assign disp_rgb     = disp_rgb_q;
    assign render_start = render_start_q;
    assign render_abort = render_abort_q;
    assign render_line  = render_line_q;
    assign busy         = (state_q == ST_RENDER);
    assign underrun     = underrun_q;
    assign underrun_cnt = underrun_cnt_q;

endmodule

// File: doc/video_linebuf_ctrl.md
VIDEO_LINEBUF_CTRL -- requirements
Module: video_linebuf_ctrl

Interface
REQ-001 Parameters SHALL be: H_ACTIVE, default 640, pixels per line; V_ACTIVE, default 480, active lines; V_TOTAL, default 525, total lines per frame.
REQ-002 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-003 rst  input  1  asynchronous active-high reset.
REQ-004 clk  input  1  pixel clock; all state updates on its rising edge.
REQ-005 start_of_screen  input  1  one-cycle pulse in the last cycle of the frame; always coincides with start_of_line.
REQ-006 start_of_line  input  1  one-cycle pulse in the last cycle of each line.
REQ-007 enable  input  1  allows new line renders.
REQ-008 disp_idx  input  10  pixel index read by the display.
REQ-009 disp_rgb  output  12  pixel data from the display bank at disp_idx.
REQ-010 render_start  output  1  one-cycle pulse requesting a line render.
REQ-011 render_abort  output  1  one-cycle pulse cancelling the in-progress render.
REQ-012 render_line  output  9  target line number of the current request.
REQ-013 render_done  input  1  one-cycle pulse from the renderer when the line is complete.
REQ-014 wr_en, wr_idx[9:0], wr_data[11:0]  inputs  renderer pixel write port.
REQ-015 busy  output  1  high while in RENDER.
REQ-016 underrun  output  1  one-cycle pulse when a line was not ready in time.
REQ-017 underrun_cnt  output  8  saturating underrun count.

Function
REQ-018 The block SHALL contain two H_ACTIVE x 12 pixel banks and a disp_bank register; the render bank SHALL be ~disp_bank.
REQ-019 Display read SHALL have 2-cycle latency: disp_idx and disp_bank registered in cycle 1, data registered onto disp_rgb in cycle 2.
REQ-020 The internal line counter y SHALL load 0 on start_of_screen, else increment on start_of_line; y_next denotes the line beginning after the pulse.
REQ-021 The FSM SHALL have states IDLE, RENDER and DONE.
REQ-022 On each start_of_line, if state is DONE (or RENDER with render_done high in the same cycle), disp_bank SHALL toggle with no underrun.
REQ-023 On start_of_line, the next target t SHALL be 0 if y_next == V_TOTAL-1, else y_next+1.
REQ-024 If t < V_ACTIVE and enable=1, render_start SHALL pulse with render_line=t and the state SHALL become RENDER; otherwise the state SHALL become IDLE.
REQ-025 On start_of_line in RENDER without render_done: underrun and render_abort SHALL pulse, disp_bank SHALL hold, and underrun_cnt SHALL increment and saturate at 255.
REQ-026 REQ-024 SHALL still apply in the underrun cycle, so abort and a new start may pulse together.
REQ-027 If enable=0 while in RENDER at start_of_line, render_abort SHALL pulse without underrun or count.
REQ-028 render_done in RENDER outside start_of_line SHALL move the state to DONE; render_done in any other state SHALL be ignored.
REQ-029 wr_en SHALL write wr_data to the render bank at wr_idx only in RENDER; writes with wr_idx >= H_ACTIVE or in other states SHALL be ignored.
REQ-030 A write and a display read to the same bank SHALL never occur, since the banks are exclusive by construction.

Reset
REQ-031 While rst is high: state IDLE; y, disp_bank, render_line and underrun_cnt 0; render_start, render_abort, underrun, busy and disp_rgb 0.
REQ-032 Bank contents SHALL NOT be reset.
REQ-033 Reset asserted mid-render SHALL take effect immediately, with no abort pulse.
REQ-034 After reset, no render SHALL start until the first start_of_line.

Verification
REQ-035 Pulse start_of_line until y_next=524 -> render_start, render_line=0; write idx 5 = 0xABC, render_done; start_of_screen -> disp_bank toggles; disp_idx=5 -> disp_rgb=0xABC two cycles later.
REQ-036 Withhold render_done for line 10 -> at next start_of_line: underrun=1, render_abort=1, render_start=1 with render_line=11, underrun_cnt=1, disp_bank unchanged.
REQ-037 render_done in the same cycle as start_of_line -> swap, underrun=0, underrun_cnt unchanged.
REQ-038 start_of_line with y_next=479 -> target 480, no render_start, IDLE through y 480..523, no underrun.
REQ-039 300 consecutive underruns -> underrun_cnt=255; wr_en in IDLE leaves bank data unchanged.
REQ-040 Assert rst mid-RENDER -> all outputs 0 asynchronously, busy=0, subsequent render_done ignored.
